// File: rtl/fft_sample_framer.sv
// Captures one complex sample per divided-clock rising edge, tags it with its
// point index, and queues it in a show-ahead FIFO for the FFT core.
module fft_sample_framer #(
  parameter int DATA_W     = 16,
  parameter int FFT_N      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_div,
  input  logic                     en,
  input  logic [DATA_W-1:0]        din_re,
  input  logic [DATA_W-1:0]        din_im,
  input  logic                     clear_ovf,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [DATA_W-1:0]        dout_re,
  output logic [DATA_W-1:0]        dout_im,
  output logic [$clog2(FFT_N)-1:0] dout_idx,
  output logic                     dout_sop,
  output logic                     dout_eop,
  output logic                     ovf
);

  localparam int IW = $clog2(FFT_N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 2 * DATA_W + IW;
  localparam logic [AW:0]   FULL_CNT = AW'(FIFO_DEPTH - 1) + 1'b1;
  localparam logic [IW-1:0] LAST_IDX = IW'(FFT_N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          div_q;
  logic [IW-1:0] idx;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [EW-1:0] head;

  logic rise;
  logic empty;
  logic full;
  logic pop;
  logic cap;
  logic wr;
  logic drop;

  assign rise  = clk_div & ~div_q;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign pop   = ~empty & dout_ready;
  assign cap   = (state == RUN) & en & rise;
  // A full FIFO still takes the sample when the head leaves this cycle.
  assign wr    = cap & (~full | pop);
  assign drop  = cap & full & ~pop;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN:  if (!en) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= 1'b0;
      state  <= IDLE;
      idx    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      div_q <= clk_div;
      state <= state_nxt;
      if ((state == RUN && !en) || drop)
        idx <= '0;
      else if (wr)
        idx <= idx + 1'b1;
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr && !pop)
        count <= count + 1'b1;
      else if (pop && !wr)
        count <= count - 1'b1;
      if (drop)
        ovf <= 1'b1;
      else if (clear_ovf)
        ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {din_re, din_im, idx};
  end

  assign head       = empty ? '0 : mem[rd_ptr];
  assign dout_valid = ~empty;
  assign dout_re    = head[EW-1 -: DATA_W];
  assign dout_im    = head[IW +: DATA_W];
  assign dout_idx   = head[IW-1:0];
  assign dout_sop   = ~empty & (dout_idx == '0);
  assign dout_eop   = ~empty & (dout_idx == LAST_IDX);

endmodule

// File: tb/tb_fft_sample_framer.sv
// Directed scenarios plus randomized traffic for fft_sample_framer,
// checked every cycle against a queue-based reference model.
module tb_fft_sample_framer;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int D  = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_div;
  logic          en;
  logic [DW-1:0] din_re;
  logic [DW-1:0] din_im;
  logic          clear_ovf;
  logic          dout_valid;
  logic          dout_ready;
  logic [DW-1:0] dout_re;
  logic [DW-1:0] dout_im;
  logic [IW-1:0] dout_idx;
  logic          dout_sop;
  logic          dout_eop;
  logic          ovf;

  always #5 clk = ~clk;

  fft_sample_framer #(.DATA_W(DW), .FFT_N(N), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .clk_div(clk_div),
    .en(en),
    .din_re(din_re),
    .din_im(din_im),
    .clear_ovf(clear_ovf),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_re(dout_re),
    .dout_im(dout_im),
    .dout_idx(dout_idx),
    .dout_sop(dout_sop),
    .dout_eop(dout_eop),
    .ovf(ovf)
  );

  typedef struct packed {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [IW-1:0] idx;
  } ent_t;

  int   checks   = 0;
  int   failures = 0;
  bit   chk_on   = 1'b0;
  ent_t mq[$];
  bit   m_run;
  bit   m_div;
  bit   m_ovf;
  int   m_idx;
  int   seen[$];
  int   exp_q[$];
  int   half = 4;
  int   dcnt = 0;
  int   kk   = 0;
  bit   rnd  = 1'b0;
  bit   rise_pending = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, frame index as a plain counter.
  always @(posedge clk) begin
    bit rise_m;
    bit pop_m;
    bit full_m;
    bit drop_m;
    if (rst) begin
      mq.delete();
      m_run = 0;
      m_div = 0;
      m_ovf = 0;
      m_idx = 0;
    end else begin
      rise_m = clk_div && !m_div;
      m_div  = clk_div;
      pop_m  = (mq.size() > 0) && dout_ready;
      full_m = (mq.size() == D);
      drop_m = 0;
      if (pop_m) void'(mq.pop_front());
      if (m_run && en && rise_m) begin
        if (full_m && !pop_m) begin
          drop_m = 1;
          m_idx  = 0;
        end else begin
          mq.push_back('{re: din_re, im: din_im, idx: m_idx[IW-1:0]});
          m_idx = (m_idx + 1) % N;
        end
      end
      if (drop_m) m_ovf = 1;
      else if (clear_ovf) m_ovf = 0;
      if (m_run && !en) begin
        m_run = 0;
        m_idx = 0;
      end else if (!m_run && en) begin
        m_run = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", dout_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("re", dout_re, mq[0].re);
        chk("im", dout_im, mq[0].im);
        chk("idx", dout_idx, mq[0].idx);
        chk("sop", dout_sop, mq[0].idx == 0);
        chk("eop", dout_eop, mq[0].idx == IW'(N - 1));
        if (dout_valid && dout_ready) seen.push_back(int'(dout_idx));
      end else begin
        chk("empty_out", {dout_re, dout_im, dout_idx, dout_sop, dout_eop}, '0);
      end
      chk("ovf", ovf, m_ovf);
    end
  end

  task automatic tick();
    bit prev;
    @(posedge clk);
    #1;
    prev = clk_div;
    dcnt = (dcnt + 1) % (2 * half);
    clk_div = (dcnt < half);
    rise_pending = clk_div && !prev;
    if (rise_pending) begin
      din_re = rnd ? DW'($urandom) : DW'(kk);
      din_im = rnd ? DW'($urandom) : DW'(-kk);
      kk++;
    end
  endtask

  task automatic wait_rises(input int n);
    repeat (n) begin
      while (!rise_pending) tick();
      tick();
    end
  endtask

  task automatic restart();
    en = 0;
    tick();
    tick();
    en = 1;
    tick();
    while (clk_div) tick();
  endtask

  task automatic check_seen(input string nm);
    chk({nm, "_cnt"}, seen.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < seen.size()) chk(nm, seen[i], exp_q[i]);
  endtask

  initial begin
    rst = 1; en = 0; clk_div = 0; clear_ovf = 0; dout_ready = 0;
    din_re = '0; din_im = '0;
    tick();
    chk_on = 1;
    chk("rst_valid", dout_valid, 0);
    chk("rst_ovf", ovf, 0);
    tick();
    rst = 0;

    // Basic frame.
    seen.delete();
    en = 1; dout_ready = 1;
    tick();
    while (clk_div) tick();
    kk = 0;
    wait_rises(16);
    repeat (4) tick();
    exp_q = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    check_seen("basic_idx");
    chk("basic_ovf", ovf, 0);

    // Backpressure within capacity.
    dout_ready = 0;
    seen.delete();
    wait_rises(3);
    chk("bp_valid", dout_valid, 1);
    chk("bp_head", dout_idx, 0);
    repeat (3) tick();
    dout_ready = 1;
    repeat (4) tick();
    exp_q = '{0, 1, 2};
    check_seen("bp_idx");
    chk("bp_ovf", ovf, 0);

    // Overflow, with clear_ovf colliding with the first drop.
    restart();
    dout_ready = 0;
    seen.delete();
    wait_rises(4);
    while (!rise_pending) tick();
    clear_ovf = 1;
    tick();
    clear_ovf = 0;
    chk("set_wins", ovf, 1);
    wait_rises(1);
    chk("ovf_sticky", ovf, 1);
    chk("ovf_depth", mq.size(), 4);
    dout_ready = 1;
    repeat (5) tick();
    wait_rises(1);
    repeat (2) tick();
    exp_q = '{0, 1, 2, 3, 0};
    check_seen("ovf_idx");
    clear_ovf = 1;
    tick();
    clear_ovf = 0;
    chk("clear_ovf", ovf, 0);

    // Full FIFO with a pop in the capture cycle.
    restart();
    dout_ready = 0;
    seen.delete();
    wait_rises(4);
    while (!rise_pending) tick();
    dout_ready = 1;
    tick();
    dout_ready = 0;
    chk("fullpop_ovf", ovf, 0);
    chk("fullpop_depth", mq.size(), 4);
    chk("fullpop_valid", dout_valid, 1);
    dout_ready = 1;
    repeat (5) tick();
    exp_q = '{0, 1, 2, 3, 4};
    check_seen("fullpop_idx");

    // en dropped mid-frame, then re-enabled.
    restart();
    dout_ready = 1;
    seen.delete();
    wait_rises(6);
    en = 0;
    repeat (10) tick();
    en = 1;
    tick();
    wait_rises(2);
    repeat (3) tick();
    exp_q = '{0, 1, 2, 3, 4, 5, 0, 1};
    check_seen("en_idx");

    // Reset with two entries buffered.
    dout_ready = 0;
    wait_rises(2);
    chk("pre_rst_valid", dout_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_ovf", ovf, 0);

    // Randomized traffic.
    rnd = 1;
    en = 1;
    repeat (4000) begin
      if ($urandom_range(0, 99) < 3) half = $urandom_range(1, 5);
      if ($urandom_range(0, 99) < 2) en = !en;
      dout_ready = ($urandom_range(0, 99) < 55);
      clear_ovf  = ($urandom_range(0, 99) < 5);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; clear_ovf = 0; dout_ready = 1; en = 0;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_sample_framer.md
Name: fft_sample_framer

Overview:
- Sits directly downstream of the even clock divider in the FFT front end.
- Uses the divided clock, which is synchronous to clk, as a sample-rate timing reference. Each clk_div rising edge captures one complex input sample.
- Tags each captured sample with its point index and frame flags, then buffers it in a small FIFO.
- Presents the buffered samples to the radix-2 DIF FFT core over a valid/ready interface in the fast clk domain.

Parameters:
- DATA_W, 16, width of each real/imag sample component
- FFT_N, 16, points per frame; power of 2, >=2
- FIFO_DEPTH, 4, sample buffer entries; power of 2, >=2

Ports:
- clk  in  1  system clock; also the source clock of clk_div
- rst  in  1  synchronous reset, active-high
- clk_div  in  1  divided clock from divider stage, sampled as data on clk
- en  in  1  capture enable
- din_re  in  DATA_W  real part of input sample
- din_im  in  DATA_W  imaginary part of input sample
- clear_ovf  in  1  single-cycle clear of sticky overflow
- dout_valid  out  1  head sample available
- dout_ready  in  1  FFT core accepts head sample
- dout_re  out  DATA_W  real part of head sample
- dout_im  out  DATA_W  imaginary part of head sample
- dout_idx  out  $clog2(FFT_N)  point index of head sample
- dout_sop  out  1  head sample is point 0
- dout_eop  out  1  head sample is point FFT_N-1
- ovf  out  1  sticky overflow flag; a sample was dropped

Behaviour:
- Reset: on rst=1 at a clk posedge, the following are cleared: div_q=0, index counter=0, FIFO empty, state=IDLE, ovf=0. Consequently dout_valid=0, dout_re/im/idx=0, dout_sop=0, dout_eop=0. Reset mid-operation discards all buffered samples.
- Edge detect: div_q <= clk_div each cycle. rise = clk_div & ~div_q, a single-cycle pulse.
- State machine, 2 states:
  - IDLE: no capture; index counter held at 0. Moves to RUN when en=1.
  - RUN: capture on rise. Moves to IDLE when en=0; a rise in that same cycle is ignored. The index counter resets to 0.
- Capture, in RUN with rise=1 in cycle T:
  - The word {din_re, din_im, idx} is written at the end of T.
  - idx then increments and wraps from FFT_N-1 to 0.
- Latency: a sample written in cycle T into an empty FIFO drives dout_valid=1 from cycle T+1.
- FIFO:
  - Show-ahead; dout_* always reflect the head entry. dout_valid = !empty.
  - A pop occurs when dout_valid & dout_ready. dout_ready with an empty FIFO is ignored.
  - dout_* hold their values while dout_valid=1 and dout_ready=0.
- Flags: dout_sop = (dout_idx==0). dout_eop = (dout_idx==FFT_N-1). Both are gated by dout_valid.
- Full boundary:
  - A write is allowed when the FIFO is full only if a pop occurs in the same cycle; occupancy is unchanged.
  - Otherwise the sample is dropped: ovf is set, and idx resets to 0 so the next accepted sample starts a new frame.
  - Entries already buffered are not modified.
- Simultaneous write and pop on an empty FIFO: the write only; no pop occurs because dout_valid=0.
- ovf:
  - Set on any drop.
  - Cleared by clear_ovf=1.
  - If a set and clear_ovf occur in the same cycle, set wins.
- en deasserted mid-frame: the partial frame already in the FIFO drains normally, without eop. The next frame starts at idx 0.
- Width rules: no arithmetic on data; samples pass bit-exact. The idx counter is $clog2(FFT_N) bits and wraps naturally.

Test Plan:
- Basic frame: FFT_N=16, clk_div period 8 clk, en=1, dout_ready=1, din_re=k, din_im=-k for sample k.
  - Required: 16 outputs with idx 0..15.
  - sop on idx 0 only, eop on idx 15 only.
  - Each output is valid 1 cycle after its capture cycle.
  - ovf stays 0.
- Backpressure within capacity: dout_ready=0 for 3 rises, then ready=1.
  - Required: 3 samples buffered and output in order with idx 0,1,2.
  - Head data is stable while stalled.
  - No drop.
- Overflow: FIFO_DEPTH=4, dout_ready=0 for 6 rises.
  - Required: 4 samples stored (idx 0..3), 5th and 6th dropped, ovf=1.
  - After ready=1, the next captured sample has idx 0 and sop=1.
- Full with simultaneous pop: FIFO full; a rise and a pop occur in the same cycle.
  - Required: sample accepted, occupancy stays 4, ovf=0.
- Clear vs set: clear_ovf=1 in the same cycle as a drop.
  - Required: ovf=1.
  - A clear_ovf pulse with no drop gives ovf=0 on the next cycle.
- Reset and en mid-frame:
  - en=0 after idx 5: capture stops and the FIFO drains.
  - en=1 again: new frame starts at idx 0.
  - rst=1 with FIFO holding 2 entries: dout_valid=0 the next cycle, and ovf=0.
